bus_arbiter_wdt: RTL
====================

// Module: bus_arbiter_wdt
// PURPOSE
//  Round-robin arbiter for the four bus masters, with a bus-timeout watchdog.
//  Sits upstream of bus_slave_mux: the grant selects which master drives the address and chip select.
//  The watchdog consumes the muxed ready (m_rdy_n) and breaks a bus lock caused by an unresponsive slave.
// PARAMETERS
//  TIMEOUT_CYCLES  255  wait cycles (strobe asserted, ready deasserted) before the watchdog fires; range 1..2^CNT_WIDTH-1
//  CNT_WIDTH       8    width of the watchdog counter
// PORTS
//  clk          in   1  system clock; all state updates on the rising edge
//  reset        in   1  synchronous, active-low reset
//  m0_req_n     in   1  master 0 bus request, active low (m1..m3 identical)
//  m1_req_n     in   1  master 1 bus request
//  m2_req_n     in   1  master 2 bus request
//  m3_req_n     in   1  master 3 bus request
//  m_as_n       in   1  address strobe of the granted master (post master-mux), active low
//  m_rdy_n      in   1  ready from bus_slave_mux, active low
//  m0_grnt_n    out  1  master 0 grant, active low (m1..m3 identical)
//  m1_grnt_n    out  1  master 1 grant
//  m2_grnt_n    out  1  master 2 grant
//  m3_grnt_n    out  1  master 3 grant
//  owner        out  2  index of the current bus owner
//  timeout_err  out  1  one-cycle pulse, active high, when the watchdog fires
// BEHAVIOUR
//  - Reset (reset==`ENABLE_ at a clk edge):
//    owner=0; m0_grnt_n=`ENABLE_; m1..m3_grnt_n=`DISABLE_; wdt_cnt=0; timeout_err=0.
//  - Grants are registered, one-hot-low, decoded from owner. Exactly one grant is asserted at all times (bus parking).
//  - Arbitration: evaluated every cycle from registered state and current requests.
//    - Owner keeps the bus while its req_n is asserted.
//    - When the owner's req_n is deasserted, the next owner is the first requester scanning owner+1, +2, +3 mod 4 (wrap 3->0).
//    - If no master requests, owner is unchanged.
//    - New grant is visible one cycle after the owner releases: latency = 1 clk.
//  - Watchdog:
//    - wdt_cnt increments when m_as_n==`ENABLE_ && m_rdy_n==`DISABLE_.
//    - wdt_cnt clears to 0 on m_rdy_n==`ENABLE_, on m_as_n==`DISABLE_, or on any owner change.
//    - When wdt_cnt==TIMEOUT_CYCLES-1 and the increment condition holds:
//      - timeout_err=1 for exactly one cycle;
//      - wdt_cnt clears;
//      - a forced release occurs: owner advances by the round-robin scan, skipping the current owner even if it still requests.
//      - If no other master requests, owner is kept, but the counter still clears and the pulse still fires.
//    - The counter never wraps; saturation is prevented by the fire condition.
//  - Simultaneous owner release and watchdog fire: a single round-robin advance occurs and timeout_err is still pulsed.
//  - Reset mid-transfer overrides everything next edge: grant returns to m0; any pending timeout is discarded (no pulse).
//  - Arithmetic: owner+k computed in 2 bits (natural mod-4 wrap); wdt_cnt is unsigned CNT_WIDTH.
// STRUCTURE
//  - Shared package/header (global_std_def and bus_def):
//    - `ENABLE_/`DISABLE_ (active-low levels);
//    - BUS_MASTER_CH=4, BUS_OWNER_W=2;
//    - owner encodings BUS_OWNER_M0..M3.
//  - One sub-module: bus_wdt_counter (counter, clear/fire logic, timeout_err register).
//  - Arbiter FSM: 4 states = owner M0..M3, each with a registered grant. Lives in the top module.
// TESTING
//  1. Reset low 2 clks -> m0_grnt_n=0, others 1, owner=0, timeout_err=0.
//  2. m0 idle, m1 and m3 request together -> m1 granted next clk; m1 releases -> m3 granted next clk.
//  3. Owner 3 releases, m0 and m2 request -> m0 granted (wrap 3->0); m0 releases with none requesting -> owner stays 0.
//  4. TIMEOUT_CYCLES=4; owner m1 holds m_as_n=0, m_rdy_n=1, m2 requesting
//     -> timeout_err pulses on the 4th stall cycle; m2 granted next clk.
//  5. Stall for 3 cycles, then m_rdy_n=0 -> counter clears; a further 3-cycle stall gives no pulse.
//  6. Reset asserted on stall cycle 3 of 4 -> no timeout_err; m0 granted; wdt_cnt=0.

Source files
------------

// File: rtl/bus_arbiter_wdt_pkg.sv
// Shared definitions for the bus arbiter: active-low levels, master count, owner encodings.
// Also holds the round-robin scan used for both normal and forced bus release.
package bus_arbiter_wdt_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;

  typedef enum logic [BUS_OWNER_W-1:0] {
    BUS_OWNER_M0 = 2'd0,
    BUS_OWNER_M1 = 2'd1,
    BUS_OWNER_M2 = 2'd2,
    BUS_OWNER_M3 = 2'd3
  } bus_owner_e;

  // First requester at cur+1, cur+2, cur+3 (mod 4); the current owner is never chosen.
  // Returns cur when nobody else is requesting.
  function automatic logic [BUS_OWNER_W-1:0] rr_scan(
    input logic [BUS_OWNER_W-1:0]   cur,
    input logic [BUS_MASTER_CH-1:0] req
  );
    logic [BUS_OWNER_W-1:0] cand;
    rr_scan = cur;
    for (int k = BUS_MASTER_CH - 1; k >= 1; k--) begin
      cand = cur + BUS_OWNER_W'(k);
      if (req[cand]) rr_scan = cand;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_wdt_wdt_counter.sv
// Bus-timeout watchdog: counts strobe-without-ready cycles and fires at TIMEOUT_CYCLES.
// The fire strobe is combinational (feeds the arbiter); timeout_err is its registered pulse.
module bus_wdt_counter
  import bus_arbiter_wdt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic m_as_n,
  input  logic m_rdy_n,
  input  logic owner_chg,
  output logic fire,
  output logic timeout_err
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 stall;

  always_comb begin
    stall         = (m_as_n == ENABLE_) && (m_rdy_n == DISABLE_);
    fire          = stall && (wdt_cnt_q == LIMIT);
    timeout_err_d = fire;
    wdt_cnt_d     = wdt_cnt_q + CNT_WIDTH'(1);
    // Firing clears too, so the counter can never wrap past LIMIT.
    if (!stall || fire || owner_chg) wdt_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset == ENABLE_) begin
      wdt_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdt_cnt_q     <= wdt_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: rtl/bus_arbiter_wdt.sv
// Round-robin arbiter for four bus masters with a bus-lock watchdog; grants are registered (1 clk).
// Owner holds the bus while requesting; watchdog fire forces a round-robin advance past the owner.
module bus_arbiter_wdt
  import bus_arbiter_wdt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_n,
  input  logic                   m1_req_n,
  input  logic                   m2_req_n,
  input  logic                   m3_req_n,
  input  logic                   m_as_n,
  input  logic                   m_rdy_n,
  output logic                   m0_grnt_n,
  output logic                   m1_grnt_n,
  output logic                   m2_grnt_n,
  output logic                   m3_grnt_n,
  output logic [BUS_OWNER_W-1:0] owner,
  output logic                   timeout_err
);

  bus_owner_e               state_q, state_d;
  logic [BUS_MASTER_CH-1:0] grnt_q, grnt_d;
  logic [BUS_MASTER_CH-1:0] req;
  logic                     wdt_fire;
  logic                     owner_chg;

  assign req = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};

  always_comb begin
    state_d = state_q;
    if (!req[state_q] || wdt_fire) state_d = bus_owner_e'(rr_scan(state_q, req));
    owner_chg = (state_d != state_q);

    grnt_d = {BUS_MASTER_CH{DISABLE_}};
    case (state_d)
      BUS_OWNER_M0: grnt_d[0] = ENABLE_;
      BUS_OWNER_M1: grnt_d[1] = ENABLE_;
      BUS_OWNER_M2: grnt_d[2] = ENABLE_;
      BUS_OWNER_M3: grnt_d[3] = ENABLE_;
      default:      grnt_d[0] = ENABLE_;
    endcase
  end

  // Bus parks on m0 out of reset.
  always_ff @(posedge clk) begin
    if (reset == ENABLE_) begin
      state_q <= BUS_OWNER_M0;
      grnt_q  <= {DISABLE_, DISABLE_, DISABLE_, ENABLE_};
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
    end
  end

  bus_wdt_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_wdt (
    .clk        (clk),
    .reset      (reset),
    .m_as_n     (m_as_n),
    .m_rdy_n    (m_rdy_n),
    .owner_chg  (owner_chg),
    .fire       (wdt_fire),
    .timeout_err(timeout_err)
  );

  assign {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n} = grnt_q;
  assign owner = state_q;

endmodule
